// File: rtl/synd_cal_3_order_ctrl.sv
// Syndrome accumulator controller for a triple-error-correcting BCH decoder
// over GF(2^10), primitive polynomial x^10 + x^3 + 1.
// Received bits arrive lowest-degree first. For each accepted bit k, the block
// drives alpha^k to a shared power datapath. It then folds the returned
// alpha^k, alpha^3k and alpha^5k into S1, S3 and S5.
module synd_cal_3_order_ctrl #(
  parameter int CODE_LEN = 1023
) (
  input  logic       clk,
  input  logic       in_ctr_Srst,
  input  logic       in_start,
  input  logic       in_bit_valid,
  input  logic       in_bit,
  output logic [9:0] out_alpha,
  input  logic [9:0] in_pow1,
  input  logic [9:0] in_pow3,
  input  logic [9:0] in_pow5,
  output logic [9:0] out_synd1,
  output logic [9:0] out_synd3,
  output logic [9:0] out_synd5,
  output logic       out_synd_valid,
  input  logic       in_synd_ack,
  output logic       out_busy,
  output logic       out_err_detect
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter value at which the final bit of the codeword is accepted.
  localparam logic [9:0] CNT_LAST = 10'(CODE_LEN - 1);

  state_t     state_q, state_d;
  logic [9:0] alpha_q, alpha_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] synd1_q, synd1_d;
  logic [9:0] synd3_q, synd3_d;
  logic [9:0] synd5_q, synd5_d;

  // Multiply by alpha: shift left, and reduce by x^10 = x^3 + 1 on overflow.
  function automatic logic [9:0] gf_mul_alpha(input logic [9:0] a);
    return {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
  endfunction

  // Next-state and datapath update; every register holds unless told otherwise.
  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    cnt_d   = cnt_q;
    synd1_d = synd1_q;
    synd3_d = synd3_q;
    synd5_d = synd5_q;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          state_d = ACCUM;
          alpha_d = 10'h001;
          cnt_d   = 10'd0;
          synd1_d = 10'h000;
          synd3_d = 10'h000;
          synd5_d = 10'h000;
        end
      end
      ACCUM: begin
        if (in_bit_valid) begin
          synd1_d = synd1_q ^ (in_bit ? in_pow1 : 10'h000);
          synd3_d = synd3_q ^ (in_bit ? in_pow3 : 10'h000);
          synd5_d = synd5_q ^ (in_bit ? in_pow5 : 10'h000);
          alpha_d = gf_mul_alpha(alpha_q);
          cnt_d   = cnt_q + 10'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (in_synd_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset returns to an empty, idle frame.
  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      state_q <= IDLE;
      alpha_q <= 10'h001;
      cnt_q   <= 10'd0;
      synd1_q <= 10'h000;
      synd3_q <= 10'h000;
      synd5_q <= 10'h000;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      cnt_q   <= cnt_d;
      synd1_q <= synd1_d;
      synd3_q <= synd3_d;
      synd5_q <= synd5_d;
    end
  end

  // Status outputs decoded directly from the state and syndrome registers.
  always_comb begin
    out_alpha      = alpha_q;
    out_synd1      = synd1_q;
    out_synd3      = synd3_q;
    out_synd5      = synd5_q;
    out_busy       = (state_q == ACCUM);
    out_synd_valid = (state_q == DONE);
    out_err_detect = (|(synd1_q | synd3_q | synd5_q)) & (state_q == DONE);
  end

endmodule

// File: tb/tb_synd_cal_3_order_ctrl.sv
// Directed bench for synd_cal_3_order_ctrl with a behavioural GF(2^10) power
// datapath hooked to out_alpha/in_pow*.
module tb_synd_cal_3_order_ctrl;

  localparam int CL = 1023;

  logic       clk = 1'b0;
  logic       in_ctr_Srst, in_start, in_bit_valid, in_bit, in_synd_ack;
  logic [9:0] out_alpha, in_pow1, in_pow3, in_pow5;
  logic [9:0] out_synd1, out_synd3, out_synd5;
  logic       out_synd_valid, out_busy, out_err_detect;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // General GF(2^10) multiply, shift-and-add from the MSB of b.
  function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] r;
    r = 10'h000;
    for (int i = 9; i >= 0; i--) begin
      r = {r[8:0], 1'b0} ^ (r[9] ? 10'h009 : 10'h000);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [9:0] cube(input logic [9:0] a);
    return gmul(a, gmul(a, a));
  endfunction

  function automatic logic [9:0] fifth(input logic [9:0] a);
    return gmul(cube(a), gmul(a, a));
  endfunction

  assign in_pow1 = out_alpha;
  assign in_pow3 = cube(out_alpha);
  assign in_pow5 = fifth(out_alpha);

  synd_cal_3_order_ctrl #(.CODE_LEN(CL)) dut (
    .clk(clk),
    .in_ctr_Srst(in_ctr_Srst),
    .in_start(in_start),
    .in_bit_valid(in_bit_valid),
    .in_bit(in_bit),
    .out_alpha(out_alpha),
    .in_pow1(in_pow1),
    .in_pow3(in_pow3),
    .in_pow5(in_pow5),
    .out_synd1(out_synd1),
    .out_synd3(out_synd3),
    .out_synd5(out_synd5),
    .out_synd_valid(out_synd_valid),
    .in_synd_ack(in_synd_ack),
    .out_busy(out_busy),
    .out_err_detect(out_err_detect)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference syndromes: S_j = XOR over set bits k of alpha^(j*k).
  task automatic model(input logic [CL-1:0] bits,
                       output logic [9:0] s1, output logic [9:0] s3, output logic [9:0] s5);
    logic [9:0] a;
    a = 10'h001; s1 = '0; s3 = '0; s5 = '0;
    for (int k = 0; k < CL; k++) begin
      if (bits[k]) begin
        s1 = s1 ^ a;
        s3 = s3 ^ cube(a);
        s5 = s5 ^ fifth(a);
      end
      a = gmul(a, 10'h002);
    end
  endtask

  // One full frame. The optional gaps carry start pulses that must be ignored.
  // The frame is acknowledged together with a start, which must also be ignored.
  task automatic run_frame(input logic [CL-1:0] bits, input bit gaps, input string tag);
    logic [9:0] e1, e3, e5, a;
    int g;
    model(bits, e1, e3, e5);
    @(negedge clk); in_start = 1'b1;
    @(negedge clk); in_start = 1'b0;
    chk({tag, "_busy_start"}, out_busy, 1'b1);
    chk({tag, "_alpha_start"}, out_alpha, 10'h001);
    a = 10'h001;
    for (int k = 0; k < CL; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) begin
          in_bit_valid = 1'b0;
          in_bit = 1'b1;
          in_start = (j == 0);
          @(negedge clk);
        end
        in_start = 1'b0;
        if (g > 0) begin
          chk({tag, "_gap_alpha"}, out_alpha, a);
          chk({tag, "_gap_busy"}, out_busy, 1'b1);
        end
      end
      if (k == 1)  chk({tag, "_alpha1"}, out_alpha, 10'h002);
      if (k == 10) chk({tag, "_alpha10"}, out_alpha, 10'h009);
      if (k == CL - 1) chk({tag, "_valid_early"}, out_synd_valid, 1'b0);
      in_bit_valid = 1'b1;
      in_bit = bits[k];
      @(negedge clk);
      a = gmul(a, 10'h002);
    end
    in_bit_valid = 1'b0;
    in_bit = 1'b0;
    chk({tag, "_valid"}, out_synd_valid, 1'b1);
    chk({tag, "_busy_done"}, out_busy, 1'b0);
    chk({tag, "_s1"}, out_synd1, e1);
    chk({tag, "_s3"}, out_synd3, e3);
    chk({tag, "_s5"}, out_synd5, e5);
    chk({tag, "_err"}, out_err_detect, ((e1 | e3 | e5) != 10'h000));
    // Hold in DONE while start is pulsed.
    in_start = 1'b1;
    @(negedge clk); in_start = 1'b0;
    @(negedge clk);
    chk({tag, "_hold_valid"}, out_synd_valid, 1'b1);
    chk({tag, "_hold_s1"}, out_synd1, e1);
    // Ack together with start: back to IDLE, not a new frame.
    in_synd_ack = 1'b1; in_start = 1'b1;
    @(negedge clk);
    in_synd_ack = 1'b0; in_start = 1'b0;
    chk({tag, "_ack_valid"}, out_synd_valid, 1'b0);
    chk({tag, "_ack_busy"}, out_busy, 1'b0);
    chk({tag, "_ack_err"}, out_err_detect, 1'b0);
    chk({tag, "_retain_s3"}, out_synd3, e3);
    @(negedge clk);
    chk({tag, "_idle_busy"}, out_busy, 1'b0);
  endtask

  logic [CL-1:0] bv;

  initial begin
    in_ctr_Srst = 1'b1; in_start = 1'b0; in_bit_valid = 1'b0;
    in_bit = 1'b0; in_synd_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_alpha", out_alpha, 10'h001);
    chk("rst_s1", out_synd1, 10'h000);
    chk("rst_s3", out_synd3, 10'h000);
    chk("rst_s5", out_synd5, 10'h000);
    chk("rst_valid", out_synd_valid, 1'b0);
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_err", out_err_detect, 1'b0);
    in_ctr_Srst = 1'b0;

    // Valid bits and ack in IDLE are ignored.
    in_bit_valid = 1'b1; in_bit = 1'b1; in_synd_ack = 1'b1;
    repeat (3) @(negedge clk);
    in_bit_valid = 1'b0; in_bit = 1'b0; in_synd_ack = 1'b0;
    chk("idle_alpha", out_alpha, 10'h001);
    chk("idle_s1", out_synd1, 10'h000);
    chk("idle_busy", out_busy, 1'b0);

    bv = '0;
    run_frame(bv, 1'b0, "zero");
    chk("zero_err_final", out_synd1 | out_synd3 | out_synd5, 10'h000);

    bv = '0; bv[0] = 1'b1;
    run_frame(bv, 1'b0, "bit0");
    chk("bit0_s1c", out_synd1, 10'h001);
    chk("bit0_s3c", out_synd3, 10'h001);
    chk("bit0_s5c", out_synd5, 10'h001);

    bv = '0; bv[1] = 1'b1;
    run_frame(bv, 1'b0, "bit1");
    chk("bit1_s1c", out_synd1, 10'h002);
    chk("bit1_s3c", out_synd3, 10'h008);
    chk("bit1_s5c", out_synd5, 10'h020);

    bv = '0; bv[10] = 1'b1;
    run_frame(bv, 1'b0, "bit10");
    chk("bit10_s1c", out_synd1, 10'h009);

    bv = '0; bv[1] = 1'b1; bv[10] = 1'b1;
    run_frame(bv, 1'b0, "bit1_10");
    chk("bit1_10_s1c", out_synd1, 10'h00B);

    bv = '0; bv[CL-1] = 1'b1;
    run_frame(bv, 1'b0, "bitlast");

    for (int k = 0; k < CL; k++) bv[k] = 1'($urandom_range(0, 1));
    run_frame(bv, 1'b0, "rand_nogap");
    run_frame(bv, 1'b1, "rand_gap");

    // Reset mid-frame at bit 500, with start/valid/ack asserted at the same edge.
    @(negedge clk); in_start = 1'b1;
    @(negedge clk); in_start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      in_bit_valid = 1'b1; in_bit = 1'b1;
      @(negedge clk);
    end
    chk("mid_busy", out_busy, 1'b1);
    in_ctr_Srst = 1'b1; in_start = 1'b1; in_synd_ack = 1'b1;
    @(negedge clk);
    in_ctr_Srst = 1'b0; in_start = 1'b0; in_synd_ack = 1'b0;
    chk("mrst_busy", out_busy, 1'b0);
    chk("mrst_valid", out_synd_valid, 1'b0);
    chk("mrst_alpha", out_alpha, 10'h001);
    chk("mrst_s1", out_synd1, 10'h000);
    chk("mrst_s5", out_synd5, 10'h000);
    // Bits still arriving after reset must not restart the frame.
    repeat (4) @(negedge clk);
    in_bit_valid = 1'b0; in_bit = 1'b0;
    chk("mrst_idle_s1", out_synd1, 10'h000);
    chk("mrst_idle_alpha", out_alpha, 10'h001);
    chk("mrst_idle_busy", out_busy, 1'b0);

    bv = '0; bv[1] = 1'b1;
    run_frame(bv, 1'b0, "after_rst");
    chk("after_rst_s1c", out_synd1, 10'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synd_cal_3_order_ctrl.md
SYND_CAL_3_ORDER_CTRL -- requirements
Module: synd_cal_3_order_ctrl

Interface
REQ-001 The block SHALL have parameter CODE_LEN, default 1023, meaning the number of received bits per codeword (2..1023).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port in_ctr_Srst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_start, input, 1 bit: frame start request, one-cycle pulse.
REQ-005 The block SHALL have port in_bit_valid, input, 1 bit: in_bit carries the next received bit this cycle.
REQ-006 The block SHALL have port in_bit, input, 1 bit: received codeword bit, lowest-degree position first.
REQ-007 The block SHALL have port out_alpha, output, 10 bits: current GF(2^10) element alpha^k, driven to the shared power datapath.
REQ-008 The block SHALL have ports in_pow1, in_pow3 and in_pow5, input, 10 bits each: datapath results (out_alpha)^1, ^3 and ^5, combinational from out_alpha.
REQ-009 The block SHALL have ports out_synd1, out_synd3 and out_synd5, output, 10 bits each: accumulated syndromes S1, S3 and S5.
REQ-010 The block SHALL have port out_synd_valid, output, 1 bit: syndromes are final and held.
REQ-011 The block SHALL have port in_synd_ack, input, 1 bit: consumer accepts the syndromes.
REQ-012 The block SHALL have port out_busy, output, 1 bit: a frame is being accumulated.
REQ-013 The block SHALL have port out_err_detect, output, 1 bit: at least one final syndrome is nonzero; qualified by out_synd_valid.

Function
REQ-014 The field SHALL be GF(2^10) with primitive polynomial x^10+x^3+1; the multiply-by-alpha step is a left shift, and if bit 9 was set the result is XORed with 10'h009.
REQ-015 The FSM SHALL have three states, IDLE, ACCUM and DONE; out_busy=1 only in ACCUM and out_synd_valid=1 only in DONE.
REQ-016 In IDLE, in_start=1 SHALL cause: next state ACCUM, alpha register <= 10'h001, bit counter <= 0, synd1/3/5 <= 0.
REQ-017 In IDLE, in_bit_valid and in_synd_ack SHALL be ignored.
REQ-018 In ACCUM, an accepted bit (in_bit_valid=1) SHALL cause: synd_j <= synd_j XOR (in_bit ? in_powj : 0) for j=1,3,5; alpha register <= alpha register * alpha; counter +1.
REQ-019 In ACCUM with in_bit_valid=0, all registers SHALL hold; gaps of any length are legal.
REQ-020 Accepting the bit with counter = CODE_LEN-1 SHALL move the FSM to DONE; out_synd_valid SHALL assert the cycle after the last bit is accepted.
REQ-021 out_alpha SHALL equal the alpha register, so accepted bit k is weighted by alpha^k; the register returns to 10'h001 only after 1023 steps and never wraps within a frame.
REQ-022 In DONE, out_synd1/3/5 and out_err_detect SHALL hold stable until in_synd_ack=1; the FSM then goes to IDLE on the next edge, with syndrome values retained.
REQ-023 in_start SHALL be ignored in ACCUM and DONE, including a start coinciding with ack; an ignored start does not restart the frame.
REQ-024 out_err_detect SHALL be combinational OR-reduce of synd1|synd3|synd5 AND out_synd_valid.
REQ-025 The counter SHALL be 10 bits wide; all syndrome arithmetic is bitwise XOR with no carries.

Reset
REQ-026 in_ctr_Srst=1 at a clock edge SHALL force: state IDLE, alpha register 10'h001, counter 0, out_synd1/3/5 = 0, out_synd_valid=0, out_busy=0, out_err_detect=0.
REQ-027 Reset SHALL take priority over start, valid and ack in the same cycle.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next frame requires a new in_start.

Verification
REQ-029 Bench SHALL cover: start, 1023 valid bits all 0 -> out_synd_valid one cycle after the last bit; S1=S3=S5=0; out_err_detect=0.
REQ-030 Bench SHALL cover: only bit 0 =1 -> S1=S3=S5=10'h001; out_err_detect=1.
REQ-031 Bench SHALL cover: only bit 1 =1 -> S1=10'h002, S3=10'h008, S5=10'h020.
REQ-032 Bench SHALL cover: only bit 10 =1 -> S1=10'h009; bits 1 and 10 both =1 -> S1=10'h00B.
REQ-033 Bench SHALL cover: random valid gaps plus in_start pulses during ACCUM -> identical syndromes to the gap-free run; frame is not restarted.
REQ-034 Bench SHALL cover: reset asserted at bit 500, then a new frame with only bit 1 =1 -> S1=10'h002, with no residue from the first frame.
